// File: rtl/param_name_detector_if.sv
// Byte-stream, pattern-configuration and detection-status bundle for param_name_detector.
// The front end drives through master; the detector attaches as slave.
interface param_name_detector_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [7:0]       data;
  logic             data_valid;
  logic             cfg_wr;
  logic [IW-1:0]    cfg_idx;
  logic [7:0]       cfg_char;
  logic [LW-1:0]    cfg_len;
  logic             cnt_clr;
  logic             match;
  logic [LW-1:0]    progress;
  logic [1:0]       stage;
  logic [CNT_W-1:0] match_count;

  modport master (
    output data, data_valid, cfg_wr, cfg_idx, cfg_char, cfg_len, cnt_clr,
    input  match, progress, stage, match_count
  );

  modport slave (
    input  data, data_valid, cfg_wr, cfg_idx, cfg_char, cfg_len, cnt_clr,
    output match, progress, stage, match_count
  );
endinterface

// File: rtl/param_name_detector.sv
// Runtime-programmable streaming ASCII pattern detector with overlap-aware prefix tracking.
// Optional build macro PND_CASE_FOLD_EN folds 'A'..'Z' to lowercase inside the comparators.
module param_name_detector #(
  parameter int                   MAX_LEN     = 16,
  parameter int                   DEF_LEN     = 12,
  parameter logic [8*MAX_LEN-1:0] DEF_PATTERN = (8*MAX_LEN)'(96'h72616D754B20687369_6E614D),
  parameter int                   PART_LEN    = 6,
  parameter int                   CNT_W       = 16
) (
  input logic                  clk,
  input logic                  reset,
  param_name_detector_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [7:0]       hist_r [MAX_LEN];
  logic [7:0]       hist_s [MAX_LEN];
  logic [7:0]       pat_r  [MAX_LEN];
  logic [7:0]       pat_s  [MAX_LEN];
  logic [LW-1:0]    len_r;
  logic [LW-1:0]    len_s;
  logic [LW-1:0]    fill_r;
  logic [LW-1:0]    fill_s;
  logic [LW-1:0]    best_s;
  logic             full_s;
  logic             match_r;
  logic             match_s;
  logic [LW-1:0]    progress_r;
  logic [LW-1:0]    progress_s;
  logic [1:0]       stage_r;
  logic [1:0]       stage_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;

  function automatic logic [7:0] fold_char(input logic [7:0] c);
`ifdef PND_CASE_FOLD_EN
    if ((c >= 8'h41) && (c <= 8'h5A)) begin
      return c + 8'h20;
    end else begin
      return c;
    end
`else
    return c;
`endif
  endfunction

  // Next history, pattern, length and fill level; cfg_wr wins over data and flushes the stream.
  always_comb begin
    hist_s = hist_r;
    pat_s  = pat_r;
    len_s  = len_r;
    fill_s = fill_r;
    if (bus.cfg_wr) begin
      if (int'(bus.cfg_idx) < MAX_LEN) begin
        pat_s[bus.cfg_idx] = bus.cfg_char;
      end else begin
        pat_s = pat_r;
      end
      len_s  = (bus.cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.cfg_len;
      fill_s = {LW{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
        hist_s[i] = 8'h00;
      end
    end else if (bus.data_valid) begin
      hist_s[0] = bus.data;
      for (int i = 1; i < MAX_LEN; i++) begin
        hist_s[i] = hist_r[i-1];
      end
      fill_s = (fill_r == LW'(MAX_LEN)) ? fill_r : fill_r + LW'(1);
    end else begin
      hist_s = hist_r;
    end
  end

  // Longest pattern prefix ending at the newest character; only characters accepted since
  // the stream start take part, so cleared history never aliases a pattern byte of 0x00.
  always_comb begin : prefix_search
    logic ok_v;
    best_s = {LW{1'b0}};
    ok_v   = 1'b0;
    for (int k = 1; k <= MAX_LEN; k++) begin
      ok_v = (LW'(k) <= len_r) && (LW'(k) <= fill_s);
      for (int j = 0; j < MAX_LEN; j++) begin
        if (j < k) begin
          ok_v = ok_v &&
                 (fold_char(hist_s[(k - 1 - j + MAX_LEN) % MAX_LEN]) == fold_char(pat_r[j]));
        end else begin
          ok_v = ok_v;
        end
      end
      if (ok_v) begin
        best_s = LW'(k);
      end else begin
        best_s = best_s;
      end
    end
    full_s = (len_r != {LW{1'b0}}) && (best_s == len_r);
  end

  // Output and counter next-state: results refresh on accepted data, hold across gaps.
  always_comb begin
    match_s    = 1'b0;
    progress_s = progress_r;
    stage_s    = 2'd0;
    if (bus.cfg_wr) begin
      progress_s = {LW{1'b0}};
    end else if (bus.data_valid) begin
      match_s    = full_s;
      progress_s = best_s;
      stage_s    = full_s ? 2'd2 : ((best_s >= LW'(PART_LEN)) ? 2'd1 : 2'd0);
    end else begin
      stage_s    = (progress_r >= LW'(PART_LEN)) ? 2'd1 : 2'd0;
    end

    if (bus.cnt_clr) begin
      count_s = match_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (match_s && !(&count_r)) begin
      count_s = count_r + CNT_W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // State registers with asynchronous active-low reset to the default pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        hist_r[i] <= 8'h00;
        pat_r[i]  <= DEF_PATTERN[8*i +: 8];
      end
      len_r      <= LW'(DEF_LEN);
      fill_r     <= {LW{1'b0}};
      match_r    <= 1'b0;
      progress_r <= {LW{1'b0}};
      stage_r    <= 2'd0;
      count_r    <= {CNT_W{1'b0}};
    end else begin
      hist_r     <= hist_s;
      pat_r      <= pat_s;
      len_r      <= len_s;
      fill_r     <= fill_s;
      match_r    <= match_s;
      progress_r <= progress_s;
      stage_r    <= stage_s;
      count_r    <= count_s;
    end
  end

  assign bus.match       = match_r;
  assign bus.progress    = progress_r;
  assign bus.stage       = stage_r;
  assign bus.match_count = count_r;
endmodule

// File: tb/tb_param_name_detector.sv
// Scoreboard bench for param_name_detector: a behavioural stream model predicts each cycle,
// a 16-bit-counter and a 2-bit-counter instance run side by side on the same stimulus.
module tb_param_name_detector;
  typedef struct packed {
    logic        m;
    logic [4:0]  p;
    logic [1:0]  s;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  string phase;
  exp_t  exp_q[$];

  param_name_detector_if #(.MAX_LEN(16), .CNT_W(16)) bus0 ();
  param_name_detector_if #(.MAX_LEN(16), .CNT_W(2))  bus1 ();

  param_name_detector #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus0));
  param_name_detector #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // model state
  logic [7:0] m_hist[$];
  logic [7:0] m_pat[16];
  int m_len, m_prog, m_stage, m_cnt, m_cnt2;
  bit m_match;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0h expected %0h", phase, tag, act, exp);
    end
  endtask

  function automatic logic [7:0] m_fold(input logic [7:0] c);
`ifdef PND_CASE_FOLD_EN
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
    return c;
  endfunction

  task automatic model_reset();
    string s;
    s = "Manish Kumar";
    m_hist.delete();
    for (int i = 0; i < 16; i++) m_pat[i] = (i < s.len()) ? s[i] : 8'h00;
    m_len = 12; m_prog = 0; m_stage = 0; m_cnt = 0; m_cnt2 = 0; m_match = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input bit dv, input bit cw, input int ci,
                            input logic [7:0] cc, input int cl, input bit clr);
    int n;
    bit ok;
    if (cw) begin
      if (ci < 16) m_pat[ci] = cc;
      m_len = (cl > 16) ? 16 : cl;
      m_hist.delete();
      m_match = 0; m_prog = 0; m_stage = 0;
    end else if (dv) begin
      m_hist.push_back(d);
      if (m_hist.size() > 16) void'(m_hist.pop_front());
      n = m_hist.size();
      m_prog = 0;
      for (int k = m_len; k >= 1; k--) begin
        if (k <= n && m_prog == 0) begin
          ok = 1;
          for (int j = 0; j < k; j++)
            if (m_fold(m_hist[n-k+j]) != m_fold(m_pat[j])) ok = 0;
          if (ok) m_prog = k;
        end
      end
      m_match = (m_len != 0) && (m_prog == m_len);
      m_stage = m_match ? 2 : ((m_prog >= 6) ? 1 : 0);
    end else begin
      m_match = 0;
      m_stage = (m_prog >= 6) ? 1 : 0;
    end
    if (clr) begin
      m_cnt = m_match ? 1 : 0;
      m_cnt2 = m_cnt;
    end else if (m_match) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic drive(input logic [7:0] d, input bit dv, input bit cw, input int ci,
                       input logic [7:0] cc, input int cl, input bit clr);
    exp_t e;
    exp_t g;
    @(negedge clk);
    bus0.data = d; bus0.data_valid = dv; bus0.cfg_wr = cw; bus0.cfg_idx = 4'(ci);
    bus0.cfg_char = cc; bus0.cfg_len = 5'(cl); bus0.cnt_clr = clr;
    bus1.data = d; bus1.data_valid = dv; bus1.cfg_wr = cw; bus1.cfg_idx = 4'(ci);
    bus1.cfg_char = cc; bus1.cfg_len = 5'(cl); bus1.cnt_clr = clr;
    model_step(d, dv, cw, ci, cc, cl, clr);
    e.m = m_match; e.p = 5'(m_prog); e.s = 2'(m_stage); e.c = 16'(m_cnt); e.c2 = 2'(m_cnt2);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check_eq("match", {31'd0, bus0.match}, {31'd0, g.m});
    check_eq("progress", {27'd0, bus0.progress}, {27'd0, g.p});
    check_eq("stage", {30'd0, bus0.stage}, {30'd0, g.s});
    check_eq("count", {16'd0, bus0.match_count}, {16'd0, g.c});
    check_eq("count_w2", {30'd0, bus1.match_count}, {30'd0, g.c2});
  endtask

  task automatic stream(input string s, input bit clr_last);
    for (int i = 0; i < s.len(); i++)
      drive(s[i], 1'b1, 1'b0, 0, 8'h00, 0, clr_last && (i == s.len() - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0);
  endtask

  task automatic check_reset_state();
    check_eq("rst_match", {31'd0, bus0.match}, 32'd0);
    check_eq("rst_progress", {27'd0, bus0.progress}, 32'd0);
    check_eq("rst_stage", {30'd0, bus0.stage}, 32'd0);
    check_eq("rst_count", {16'd0, bus0.match_count}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; phase = "reset";
    reset = 1'b0;
    bus0.data = 8'h00; bus0.data_valid = 1'b0; bus0.cfg_wr = 1'b0; bus0.cfg_idx = 4'd0;
    bus0.cfg_char = 8'h00; bus0.cfg_len = 5'd0; bus0.cnt_clr = 1'b0;
    bus1.data = 8'h00; bus1.data_valid = 1'b0; bus1.cfg_wr = 1'b0; bus1.cfg_idx = 4'd0;
    bus1.cfg_char = 8'h00; bus1.cfg_len = 5'd0; bus1.cnt_clr = 1'b0;
    model_reset();
    #12;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;

    phase = "basic";   stream("Manish Kumar", 1'b0);
    phase = "restart"; stream("MaMManish Kumar", 1'b0);
    phase = "gap";     stream("Mani", 1'b0); idle(5); stream("sh Kumar", 1'b0);
    phase = "midrst";  stream("Mani", 1'b0); pulse_reset(); stream("sh Kumar", 1'b0);
    phase = "cntclr";  stream("Manish Kumar", 1'b0); drive(8'h00, 1'b0, 1'b0, 0, 8'h00, 0, 1'b1);
    phase = "clrmatch"; stream("Manish Kumar", 1'b1);
    phase = "sat";     for (int i = 0; i < 4; i++) stream("Manish Kumar", 1'b0);

    phase = "cfg";
    drive(8'h00, 1'b0, 1'b1, 0, "a", 3, 1'b0);
    drive(8'h00, 1'b0, 1'b1, 1, "b", 3, 1'b0);
    drive("a",   1'b1, 1'b1, 2, "a", 3, 1'b0);
    phase = "overlap"; stream("ababa", 1'b0); idle(2);
    phase = "len0";
    drive(8'h00, 1'b0, 1'b1, 3, "c", 0, 1'b0);
    stream("abaaba", 1'b0);

    phase = "case";
    pulse_reset();
    stream("MANISH KUMAR", 1'b0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
